// File: rtl/aes_pkg.sv
// Shared AES types, round constants and the byte-level round transforms.
// A state byte i (AES order) lives at packed index 15-i.
package aes_pkg;

    typedef logic [15:0][7:0] aes_state_t;
    typedef logic [255:0]     aes_key_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } aes_fsm_t;

    localparam logic [0:7][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates left by r columns.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[15 - (r + 4 * c)] = s[15 - (r + 4 * ((c + r) % 4))];
        return o;
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[15 - 4 * c];
            a1 = s[14 - 4 * c];
            a2 = s[13 - 4 * c];
            a3 = s[12 - 4 * c];
            o[15 - 4 * c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[14 - 4 * c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[13 - 4 * c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[12 - 4 * c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box as a combinational 256-entry lookup.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [0:15][127:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Row by high nibble, byte within the row by low nibble (byte 0 is the MSB).
    assign o_byte = SBOX[i_byte[7:4]][{~i_byte[3:0], 3'b000} +: 8];

endmodule

// File: rtl/aes256_enc_axi.sv
// Register-mapped iterative AES-256 encryptor: one round per cycle with the
// key schedule rolled forward on the fly in a two-round-key window.
module aes256_enc_axi
    import aes_pkg::*;
#(
    parameter aes_key_t KEY = 256'h0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       dataIn_AXI_valid,
    input  logic       addr,
    input  aes_state_t inpAES,
    input  logic       masterRd,
    input  logic       masterRecDataRd,
    output logic       slaveRd,
    output logic       slaveValidResp,
    output aes_state_t outAES,
    output logic       dataOut_AXI_valid,
    output logic       masterSendDataRd
);
    aes_fsm_t         r_fsm;
    logic [1:0]       r_wcnt;
    logic [3:0]       r_rnd;
    logic [3:0][31:0] r_buf;
    aes_state_t       r_st;
    aes_key_t         r_key;
    aes_state_t       r_out;
    logic             r_slave_rd, r_resp, r_out_vld, r_send;

    logic             w_acc;
    logic [31:0]      w_word, w_kw, w_ksub, w_ktmp;
    logic [31:0]      w_k0, w_k1, w_k2, w_k3;
    aes_state_t       w_sb, w_sr, w_mc, w_rk;
    logic             w_unused;

    assign w_acc    = dataIn_AXI_valid && r_slave_rd;
    assign w_word   = inpAES[3:0];
    assign w_unused = ^inpAES[15:4];
    assign w_rk     = r_key[255:128];

    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (.i_byte(r_st[i]), .o_byte(w_sb[i]));
    end
    assign w_sr = shift_rows(w_sb);
    assign w_mc = mix_columns(w_sr);

    // r_key = {rk[n], rk[n+1]}; derive rk[n+2] from the last word of rk[n+1].
    assign w_kw = r_key[31:0];
    for (genvar i = 0; i < 4; i++) begin : g_ksub
        aes_sbox u_sbox (.i_byte(w_kw[8*i +: 8]), .o_byte(w_ksub[8*i +: 8]));
    end
    assign w_ktmp = r_rnd[0] ? w_ksub
                             : ({w_ksub[23:0], w_ksub[31:24]} ^ {RCON[r_rnd[3:1]], 24'h0});
    assign w_k0 = r_key[255:224] ^ w_ktmp;
    assign w_k1 = r_key[223:192] ^ w_k0;
    assign w_k2 = r_key[191:160] ^ w_k1;
    assign w_k3 = r_key[159:128] ^ w_k2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fsm      <= S_IDLE;
            r_wcnt     <= '0;
            r_rnd      <= '0;
            r_buf      <= '0;
            r_st       <= '0;
            r_key      <= '0;
            r_out      <= '0;
            r_slave_rd <= 1'b1;
            r_resp     <= 1'b0;
            r_out_vld  <= 1'b0;
            r_send     <= 1'b0;
        end else begin
            r_send <= 1'b0;
            if (w_acc)
                r_resp <= 1'b1;
            else if (masterRd)
                r_resp <= 1'b0;

            case (r_fsm)
                S_IDLE: begin
                    if (w_acc && addr) begin
                        r_buf[~r_wcnt] <= w_word;
                        r_wcnt         <= r_wcnt + 2'd1;
                    end else if (w_acc && inpAES[0][0]) begin
                        r_wcnt     <= '0;
                        r_key      <= KEY;
                        r_rnd      <= '0;
                        r_slave_rd <= 1'b0;
                        r_fsm      <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_st  <= r_buf ^ w_rk;
                    r_key <= {r_key[127:0], w_k0, w_k1, w_k2, w_k3};
                    r_rnd <= r_rnd + 4'd1;
                    r_fsm <= S_ROUND;
                end
                S_ROUND: begin
                    r_st  <= w_mc ^ w_rk;
                    r_key <= {r_key[127:0], w_k0, w_k1, w_k2, w_k3};
                    r_rnd <= r_rnd + 4'd1;
                    if (r_rnd == 4'd13)
                        r_fsm <= S_FINAL;
                end
                S_FINAL: begin
                    r_out     <= w_sr ^ w_rk;
                    r_out_vld <= 1'b1;
                    r_fsm     <= S_DONE;
                end
                S_DONE: begin
                    if (masterRecDataRd) begin
                        r_out_vld  <= 1'b0;
                        r_send     <= 1'b1;
                        r_slave_rd <= 1'b1;
                        r_fsm      <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign slaveRd           = r_slave_rd;
    assign slaveValidResp    = r_resp;
    assign outAES            = r_out;
    assign dataOut_AXI_valid = r_out_vld;
    assign masterSendDataRd  = r_send;

endmodule

// File: tb/tb_aes256_enc_axi.sv
// Bench for aes256_enc_axi: a zero-key and a FIPS-197 C.3 key instance,
// expected ciphertexts queued at START and checked when the output is taken.
module tb_aes256_enc_axi;
    import aes_pkg::*;

    localparam aes_key_t   FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] ZERO_CT = 128'hdc95c078a2408989ad48a21492842087;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic [1:0] vld, adr, mrd, mrec, srd, resp, ovld, spls;
    logic [1:0][127:0] din, dout;
    logic [127:0] exp_q0[$], exp_q1[$];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    aes256_enc_axi u_dut0 (
        .clk(clk), .resetn(resetn), .dataIn_AXI_valid(vld[0]), .addr(adr[0]),
        .inpAES(din[0]), .masterRd(mrd[0]), .masterRecDataRd(mrec[0]),
        .slaveRd(srd[0]), .slaveValidResp(resp[0]), .outAES(dout[0]),
        .dataOut_AXI_valid(ovld[0]), .masterSendDataRd(spls[0])
    );

    aes256_enc_axi #(.KEY(FIPS_KEY)) u_dut1 (
        .clk(clk), .resetn(resetn), .dataIn_AXI_valid(vld[1]), .addr(adr[1]),
        .inpAES(din[1]), .masterRd(mrd[1]), .masterRecDataRd(mrec[1]),
        .slaveRd(srd[1]), .slaveValidResp(resp[1]), .outAES(dout[1]),
        .dataOut_AXI_valid(ovld[1]), .masterSendDataRd(spls[1])
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Ciphertext is taken at the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (resetn && ovld[0] && mrec[0]) begin
            chk("dut0_out_expected", exp_q0.size() != 0, 1);
            if (exp_q0.size() != 0) chk("dut0_ciphertext", dout[0], exp_q0.pop_front());
        end
        if (resetn && ovld[1] && mrec[1]) begin
            chk("dut1_out_expected", exp_q1.size() != 0, 1);
            if (exp_q1.size() != 0) chk("dut1_ciphertext", dout[1], exp_q1.pop_front());
        end
    end

    task automatic wr(input int d, input logic a, input logic [31:0] w);
        int t = 0;
        while (!srd[d] && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 100) chk("wr_slaveRd_timeout", srd[d], 1);
        vld[d] = 1'b1;
        adr[d] = a;
        din[d] = {96'h0, w};
        @(posedge clk); #1;
        vld[d] = 1'b0;
    endtask

    task automatic load(input int d, input logic [127:0] pt);
        for (int k = 0; k < 4; k++) wr(d, 1'b1, pt[127 - 32 * k -: 32]);
    endtask

    // Returns just after E15; optionally hammers the bus while busy.
    task automatic start(input int d, input logic [127:0] exp, input bit junk);
        if (d == 0) exp_q0.push_back(exp);
        else exp_q1.push_back(exp);
        wr(d, 1'b0, 32'h1);
        chk("busy_slaveRd", srd[d], 0);
        repeat (14) begin
            if (junk) begin
                vld[d] = 1'b1;
                adr[d] = ~adr[d];
                din[d] = {96'h0, $urandom() | 32'h1};
            end
            @(posedge clk); #1;
        end
        vld[d] = 1'b0;
        chk("valid_before_E15", ovld[d], 0);
        @(posedge clk); #1;
        chk("valid_at_E15", ovld[d], 1);
    endtask

    task automatic wait_idle(input int d);
        int t = 0;
        while (!srd[d] && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("idle_reached", srd[d], 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vld = '0; adr = '0; din = '0; mrd = '1; mrec = '1;
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_slaveRd", srd[d], 1);
            chk("rst_resp", resp[d], 0);
            chk("rst_valid", ovld[d], 0);
            chk("rst_out", dout[d], 0);
            chk("rst_pulse", spls[d], 0);
        end

        // Zero key, zero plaintext.
        load(0, 128'h0);
        start(0, ZERO_CT, 1'b0);
        wait_idle(0);

        // FIPS-197 C.3.
        load(1, FIPS_PT);
        start(1, FIPS_CT, 1'b0);
        wait_idle(1);

        // Bus traffic while busy must neither corrupt the buffer nor move the counter.
        start(1, FIPS_CT, 1'b1);
        wait_idle(1);
        start(1, FIPS_CT, 1'b1);
        wait_idle(1);
        load(1, FIPS_PT);
        start(1, FIPS_CT, 1'b0);
        wait_idle(1);

        // Output held while the master stalls, then one-cycle completion pulse.
        mrec[1] = 1'b0;
        start(1, FIPS_CT, 1'b0);
        repeat (3) begin
            chk("hold_valid", ovld[1], 1);
            chk("hold_out", dout[1], FIPS_CT);
            chk("hold_pulse", spls[1], 0);
            @(posedge clk); #1;
        end
        mrec[1] = 1'b1;
        @(posedge clk); #1;
        chk("take_valid", ovld[1], 0);
        chk("take_pulse", spls[1], 1);
        chk("take_slaveRd", srd[1], 1);
        chk("take_out_held", dout[1], FIPS_CT);
        @(posedge clk); #1;
        chk("pulse_one_cycle", spls[1], 0);

        // Write response held by masterRd; START=0 only gets a response.
        mrd[1] = 1'b0;
        wr(1, 1'b0, 32'h0);
        chk("resp_rise", resp[1], 1);
        chk("ctrl0_no_start", srd[1], 1);
        repeat (3) @(posedge clk);
        #1 chk("resp_hold", resp[1], 1);
        mrd[1] = 1'b1;
        @(posedge clk); #1;
        chk("resp_clear", resp[1], 0);
        wr(1, 1'b0, 32'h0);
        wr(1, 1'b0, 32'h0);
        chk("resp_collision", resp[1], 1);
        @(posedge clk); #1;
        chk("resp_clear2", resp[1], 0);

        // Fifth data write overwrites word 0.
        wr(1, 1'b1, 32'hdeadbeef);
        wr(1, 1'b1, FIPS_PT[95:64]);
        wr(1, 1'b1, FIPS_PT[63:32]);
        wr(1, 1'b1, FIPS_PT[31:0]);
        wr(1, 1'b1, FIPS_PT[127:96]);
        start(1, FIPS_CT, 1'b0);
        wait_idle(1);

        // Reset mid-encryption aborts everything.
        mrd[1] = 1'b0;
        wr(1, 1'b0, 32'h1);
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        #1 chk("rst_mid_slaveRd", srd[1], 1);
        @(posedge clk); #1 resetn = 1'b1;
        mrd[1] = 1'b1;
        chk("rst_mid_resp", resp[1], 0);
        chk("rst_mid_valid", ovld[1], 0);
        chk("rst_mid_out", dout[1], 0);
        chk("rst_mid_out0", dout[0], 0);
        repeat (20) @(posedge clk);
        #1 chk("rst_mid_no_output", ovld[1], 0);
        chk("rst_mid_still_idle", srd[1], 1);

        load(1, FIPS_PT);
        start(1, FIPS_CT, 1'b0);
        wait_idle(1);
        chk("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aes256_enc_axi.md
# aes256_enc_axi

AXI-style register-mapped AES-256 encryption block. A bus master loads a 128-bit plaintext as four 32-bit words, then writes a start bit to a control register. The block encrypts it iteratively with a fixed 256-bit key and presents the ciphertext on a valid/ready output channel. It sits as a slave peripheral behind a simple single-bit-address write bus.

## Interface
- `KEY`, default `256'h0`: AES-256 cipher key. Bits [255:248] are key byte 0.
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `dataIn_AXI_valid` input 1: write-data valid.
- `addr` input 1: 0 selects the control register, 1 selects the plaintext data port.
- `inpAES` input [15:0][7:0]: write data. Only bits [31:0] are used.
- `masterRd` input 1: master ready to accept a write response.
- `masterRecDataRd` input 1: master ready to receive ciphertext.
- `slaveRd` output 1: block ready to accept writes.
- `slaveValidResp` output 1: write response valid.
- `outAES` output [15:0][7:0]: ciphertext. Bits [127:120] are AES byte 0.
- `dataOut_AXI_valid` output 1: ciphertext valid.
- `masterSendDataRd` output 1: one-cycle pulse when a ciphertext transfer completes.

## Operation
- **Write acceptance:** a write is accepted at a rising edge where `dataIn_AXI_valid && slaveRd` is true. Writes while `slaveRd` = 0 are dropped.
- **Data port (`addr` = 1):** each accepted write stores `inpAES[31:0]` into the plaintext buffer at the position given by a 2-bit word counter, then increments the counter.
  - Word 0 goes to bits [127:96]; word 3 goes to bits [31:0].
  - The counter wraps 3→0, so a fifth write overwrites word 0.
- **Control port (`addr` = 1'b0):** bit 0 = START; other bits are ignored.
  - A write with START = 1 clears the word counter and starts encryption of the current buffer.
  - A write with START = 0 has no effect and still gets a write response.
- **Write response:** `slaveValidResp` rises the cycle after any accepted write. It stays high until an edge where `masterRd` = 1.
- **FSM states:**
  - IDLE → INIT when START is accepted.
  - INIT: state = plaintext XOR round key 0.
  - ROUND: rounds 1–13, each SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - FINAL: round 14, with no MixColumns.
  - DONE: hold ciphertext.
  - DONE → IDLE at an edge where `masterRecDataRd` = 1.
- **Key schedule:** round keys are generated on the fly, one 128-bit round key per cycle (standard AES-256 schedule, Nk = 8, Rcon sequence 01..40). No stored expanded key.
- **Busy state:** `slaveRd` = 0 in INIT, ROUND, FINAL and DONE.
- **Output hold:** `outAES` is registered and holds its last value until the next completion.
- **Reset:** asserting `resetn` low at any time, including mid-encryption, aborts immediately. Reset values:
  - FSM = IDLE, word counter = 0, buffer = 0
  - `outAES` = 0, `dataOut_AXI_valid` = 0, `slaveValidResp` = 0, `masterSendDataRd` = 0
  - `slaveRd` = 1

## Timing
- START accepted at edge E0. INIT executes at E1. Rounds 1–14 execute at E2..E15.
- `dataOut_AXI_valid` = 1 and `outAES` valid from E15, a latency of 15 cycles from START.
- Ciphertext is consumed at the first edge Ek ≥ E16 with `masterRecDataRd` = 1:
  - `dataOut_AXI_valid` falls after Ek.
  - `masterSendDataRd` pulses high for the cycle following Ek.
  - `slaveRd` returns to 1 after Ek.
- If `masterRecDataRd` is held high, the earliest next write is accepted at E17.
- If a write and its response clear coincide, the new response wins and `slaveValidResp` stays high.

## Structure
- Shared package `aes_pkg` holds:
  - typedefs: `aes_state_t` = logic [15:0][7:0], `aes_key_t` = logic [255:0]
  - the Rcon constant array
  - functions `xtime`, `shift_rows`, `mix_columns`
- One sub-module `aes_sbox`: combinational 256-entry forward S-box. Instantiate 16 copies for SubBytes and 4 for the key schedule.
- Top level holds the FSM, the bus registers and the round datapath.

## Test plan
- **Reset:** pulse `resetn` low for one cycle mid-operation → all outputs at reset values, `slaveRd` = 1.
- **Default-key encryption:** `KEY` = 0; write words 0,0,0,0; write control 1 → after 15 cycles `outAES` = dc95c078a2408989ad48a21492842087.
- **FIPS-197 C.3:** `KEY` = 000102…1e1f; write words 00112233, 44556677, 8899aabb, ccddeeff; START → `outAES` = 8ea2b7ca516745bfeafc49904b496089, `dataOut_AXI_valid` high at E15.
- **Busy behaviour:** during busy, writes are dropped and `slaveRd` = 0. Writes 01000000, 02000000, 03000000, 04000000 then START → plaintext buffer reads 01000000020000000300000004000000.
- **Output handshake:** hold `masterRecDataRd` = 0 → `dataOut_AXI_valid` and `outAES` hold. Raise it → valid clears and `masterSendDataRd` pulses for one cycle.
- **Write response and wrap:** hold `masterRd` = 0 → `slaveValidResp` holds until `masterRd` = 1. Five data writes → word 0 is replaced by the fifth word.
